pc_next_unit: RTL and testbench

Parametrised next-PC generator and PC register for the processor front end. It selects the next fetch address from sequential, branch, JAL, JALR, exception and MRET sources. It holds the PC under stall and captures a redirect that arrives during a stall, so the redirect is not lost. It flags misaligned control-flow targets and reports the faulting address for mtval.

---
 rtl/pc_next_unit.sv | 141 ++++++++++++++
 tb/tb_pc_next_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// ============================================================================
// Module   : pc_next_unit
// Brief    : Next-PC select and PC register with stall-safe redirect capture
//            and misaligned-target reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      Control_PC_Mux,
  input  logic [XLEN-1:0] PC_branch,
  input  logic [XLEN-1:0] PC_jal,
  input  logic [XLEN-1:0] PC_jalr,
  input  logic [XLEN-1:0] PC_Exception,
  input  logic [XLEN-1:0] MRET,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect_pending,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic            sel_err
);

  localparam logic [XLEN-1:0] C_FOUR      = XLEN'(4);
  localparam logic [XLEN-1:0] C_JALR_MASK = ~XLEN'(1);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_HOLD      = 2'd1,
    S_HOLD_PEND = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [XLEN-1:0]   r_pc, w_pc_n;
  logic [XLEN-1:0]   r_pend, w_pend_n;
  logic              r_pend_exc, w_pend_exc_n;
  logic              r_misalign, r_sel_err;
  logic [XLEN-1:0]   r_bad_addr;

  logic [XLEN-1:0]   w_pc_plus4, w_tgt, w_cand;
  logic              w_chk, w_valid, w_res, w_exc, w_mret, w_mis, w_redir;

  // Source decode and target formation
  always_comb begin
    w_pc_plus4 = r_pc + C_FOUR;
    w_tgt      = '0;
    w_chk      = 1'b0;
    w_valid    = 1'b0;
    w_res      = 1'b0;
    w_exc      = 1'b0;
    w_mret     = 1'b0;
    case (Control_PC_Mux)
      3'b001: begin w_tgt = PC_branch;             w_chk = 1'b1; w_valid = 1'b1; end
      3'b011: begin w_tgt = PC_jal;                w_chk = 1'b1; w_valid = 1'b1; end
      3'b100: begin w_tgt = PC_jalr & C_JALR_MASK; w_chk = 1'b1; w_valid = 1'b1; end
      3'b101: begin w_tgt = PC_Exception;          w_exc = 1'b1; w_valid = 1'b1; end
      3'b111: begin w_tgt = MRET;                  w_mret = 1'b1; w_valid = 1'b1; end
      3'b010, 3'b110: w_res = 1'b1;
      default: ;
    endcase
    w_mis   = w_chk & (|w_tgt[ALIGN_BITS-1:0]);
    w_redir = w_valid & ~w_mis;
    w_cand  = w_redir ? w_tgt : w_pc_plus4;
  end

  // Next-state / next-PC logic
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_pend_n     = r_pend;
    w_pend_exc_n = r_pend_exc;
    case (r_state)
      S_RUN, S_HOLD: begin
        if (!stall) begin
          w_pc_n    = w_cand;
          w_state_n = S_RUN;
        end else if (w_redir) begin
          w_pend_n     = w_tgt;
          w_pend_exc_n = w_exc;
          w_state_n    = S_HOLD_PEND;
        end else begin
          w_state_n = S_HOLD;
        end
      end
      S_HOLD_PEND: begin
        if (stall) begin
          // Exceptions always win; MRET may only displace a non-exception entry
          if (w_exc) begin
            w_pend_n     = w_tgt;
            w_pend_exc_n = 1'b1;
          end else if (w_mret && !r_pend_exc) begin
            w_pend_n = w_tgt;
          end
        end else begin
          w_pc_n       = w_exc ? PC_Exception : r_pend;
          w_pend_n     = '0;
          w_pend_exc_n = 1'b0;
          w_state_n    = S_RUN;
        end
      end
      default: w_state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_pend_exc <= 1'b0;
      r_misalign <= 1'b0;
      r_sel_err  <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_pend     <= w_pend_n;
      r_pend_exc <= w_pend_exc_n;
      r_misalign <= w_mis;
      r_sel_err  <= w_res;
      if (w_mis) r_bad_addr <= w_tgt;
    end
  end

  assign pc               = r_pc;
  assign pc_plus4         = w_pc_plus4;
  assign redirect_pending = (r_state == S_HOLD_PEND);
  assign misalign         = r_misalign;
  assign bad_addr         = r_bad_addr;
  assign sel_err          = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// Module   : tb_pc_next_unit
// Brief    : Directed self-checking bench for pc_next_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  sel;
  logic [31:0] pc_branch, pc_jal, pc_jalr, pc_exc, mret;
  logic [31:0] pc, pc_plus4, bad_addr;
  logic        redirect_pending, misalign, sel_err;

  int n_cmp = 0;
  int n_err = 0;

  pc_next_unit #(
    .XLEN(32), .RESET_PC(32'h0), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .Control_PC_Mux(sel),
    .PC_branch(pc_branch), .PC_jal(pc_jal), .PC_jalr(pc_jalr),
    .PC_Exception(pc_exc), .MRET(mret),
    .pc(pc), .pc_plus4(pc_plus4), .redirect_pending(redirect_pending),
    .misalign(misalign), .bad_addr(bad_addr), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; sel = 3'b000;
    pc_branch = '0; pc_jal = '0; pc_jalr = '0; pc_exc = '0; mret = '0;
    step(); step();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h4); end
    n_cmp++; if ({redirect_pending, misalign, sel_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {redirect_pending, misalign, sel_err}); end
    n_cmp++; if (bad_addr !== 32'h0) begin n_err++; $display("FAIL reset_bad_addr got %h exp 0", bad_addr); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    sel = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pc !== exp_pc[i]) begin n_err++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
    end
    n_cmp++; if (pc_plus4 !== 32'h10) begin n_err++; $display("FAIL seq_pc_plus4 got %h exp %h", pc_plus4, 32'h10); end
  endtask

  task automatic test_stall_redirect();
    sel = 3'b011; pc_jal = 32'h100; step();
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL stall_setup_pc got %h exp 100", pc); end
    stall = 1'b1; sel = 3'b001; pc_branch = 32'h200; step();
    n_cmp++; if (pc !== 32'h100 || redirect_pending !== 1'b1) begin n_err++; $display("FAIL stall_capture got pc=%h pend=%b exp pc=100 pend=1", pc, redirect_pending); end
    sel = 3'b000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (pc !== 32'h100 || redirect_pending !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got pc=%h pend=%b exp pc=100 pend=1", i, pc, redirect_pending); end
    end
    stall = 1'b0; step();
    n_cmp++; if (pc !== 32'h200 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL stall_release got pc=%h pend=%b exp pc=200 pend=0", pc, redirect_pending); end
  endtask

  task automatic test_priority();
    // exception overrides a captured JAL
    stall = 1'b1; sel = 3'b011; pc_jal = 32'h300; step();
    sel = 3'b101; pc_exc = 32'h8000_0000; step();
    n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL exc_hold_pc got %h exp 200", pc); end
    stall = 1'b0; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL exc_override got %h exp 80000000", pc); end
    // MRET cannot displace a pending exception
    stall = 1'b1; sel = 3'b101; pc_exc = 32'h500; step();
    sel = 3'b111; mret = 32'h600; step();
    stall = 1'b0; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h500) begin n_err++; $display("FAIL mret_vs_exc got %h exp 500", pc); end
    // MRET displaces a pending branch
    stall = 1'b1; sel = 3'b001; pc_branch = 32'h700; step();
    sel = 3'b111; mret = 32'h900; step();
    stall = 1'b0; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h900) begin n_err++; $display("FAIL mret_vs_branch got %h exp 900", pc); end
    // first capture wins among branch/JAL/JALR
    stall = 1'b1; sel = 3'b011; pc_jal = 32'hA00; step();
    sel = 3'b001; pc_branch = 32'hB00; step();
    stall = 1'b0; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'hA00) begin n_err++; $display("FAIL first_capture got %h exp a00", pc); end
    // release with exception select takes PC_Exception directly
    stall = 1'b1; sel = 3'b001; pc_branch = 32'hC00; step();
    stall = 1'b0; sel = 3'b101; pc_exc = 32'hD00; step();
    n_cmp++; if (pc !== 32'hD00 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL release_exc got pc=%h pend=%b exp pc=d00 pend=0", pc, redirect_pending); end
  endtask

  task automatic test_misalign();
    stall = 1'b0; sel = 3'b011; pc_jal = 32'h40; step();
    sel = 3'b100; pc_jalr = 32'h1006; step();
    n_cmp++; if (pc !== 32'h44) begin n_err++; $display("FAIL mis_pc got %h exp 44", pc); end
    n_cmp++; if (misalign !== 1'b1 || bad_addr !== 32'h1006) begin n_err++; $display("FAIL mis_flag got mis=%b bad=%h exp mis=1 bad=1006", misalign, bad_addr); end
    sel = 3'b000; step();
    n_cmp++; if (misalign !== 1'b0 || bad_addr !== 32'h1006 || pc !== 32'h48) begin n_err++; $display("FAIL mis_pulse got mis=%b bad=%h pc=%h exp mis=0 bad=1006 pc=48", misalign, bad_addr, pc); end
    sel = 3'b100; pc_jalr = 32'h1001; step();
    n_cmp++; if (pc !== 32'h1000 || misalign !== 1'b0) begin n_err++; $display("FAIL jalr_bit0 got pc=%h mis=%b exp pc=1000 mis=0", pc, misalign); end
    // misaligned branch under stall is neither applied nor captured
    stall = 1'b1; sel = 3'b001; pc_branch = 32'h2002; step();
    n_cmp++; if (pc !== 32'h1000 || redirect_pending !== 1'b0 || misalign !== 1'b1 || bad_addr !== 32'h2002) begin n_err++; $display("FAIL mis_stall got pc=%h pend=%b mis=%b bad=%h exp 1000/0/1/2002", pc, redirect_pending, misalign, bad_addr); end
    stall = 1'b0; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h1004) begin n_err++; $display("FAIL mis_stall_release got %h exp 1004", pc); end
  endtask

  task automatic test_reserved_wrap();
    sel = 3'b011; pc_jal = 32'hFFFF_FFFC; step();
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    sel = 3'b010; step();
    n_cmp++; if (pc !== 32'h0 || sel_err !== 1'b1 || misalign !== 1'b0) begin n_err++; $display("FAIL res_wrap got pc=%h serr=%b mis=%b exp 0/1/0", pc, sel_err, misalign); end
    sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h4 || sel_err !== 1'b0) begin n_err++; $display("FAIL res_pulse got pc=%h serr=%b exp 4/0", pc, sel_err); end
    sel = 3'b110; step();
    n_cmp++; if (pc !== 32'h8 || sel_err !== 1'b1) begin n_err++; $display("FAIL res_110 got pc=%h serr=%b exp 8/1", pc, sel_err); end
    sel = 3'b000; step();
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1; sel = 3'b001; pc_branch = 32'h200; step();
    n_cmp++; if (redirect_pending !== 1'b1) begin n_err++; $display("FAIL rms_capture got pend=%b exp 1", redirect_pending); end
    rst = 1'b1; sel = 3'b000; step();
    n_cmp++; if (pc !== 32'h0 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL rms_reset got pc=%h pend=%b exp 0/0", pc, redirect_pending); end
    rst = 1'b0; step();
    stall = 1'b0; step();
    n_cmp++; if (pc !== 32'h4 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL rms_release got pc=%h pend=%b exp 4/0", pc, redirect_pending); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sels [5] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b111};
    logic [31:0] exps [5] = '{32'h100, 32'h200, 32'h304, 32'h400, 32'h500};
    stall = 1'b0;
    pc_branch = 32'h100; pc_jal = 32'h200; pc_jalr = 32'h305; pc_exc = 32'h400; mret = 32'h500;
    for (int i = 0; i < 5; i++) begin
      sel = sels[i]; step();
      n_cmp++; if (pc !== exps[i]) begin n_err++; $display("FAIL b2b[%0d] got %h exp %h", i, pc, exps[i]); end
    end
    sel = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_priority();
    test_misalign();
    test_reserved_wrap();
    test_reset_mid_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
